// File: rtl/dac_feeder.sv
// Streams MCU bytes into a 2x1024-byte ping-pong DAC buffer, pacing on the DAC's half-read status.
// Optional macro DAC_FEEDER_UNDERRUN_EN enables the saturating underrun counter.
module dac_feeder #(
   parameter int unsigned UNDERRUN_W = 8,
   parameter int unsigned HALF_BYTES = 1024
) (
   input  logic                          clkin,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   input  logic                          dac_status,
   output logic                          pgm_we,
   output logic [$clog2(HALF_BYTES):0]   pgm_address,
   output logic [7:0]                    pgm_data,
   output logic                          dac_play,
   output logic                          dac_reset,
   output logic                          busy,
   output logic [UNDERRUN_W-1:0]         underrun_count
);

   localparam int unsigned AW = $clog2(HALF_BYTES) + 1;

   typedef enum logic [2:0] {StIdle, StRst, StPrime, StFill, StWait} state_e;

   state_e          state_q, state_d;
   logic            rst_cnt_q, rst_cnt_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic            stat_q;
   logic            play_pend_q;
   logic            dac_play_q;
   logic            pgm_we_q;
   logic [AW-1:0]   pgm_address_q;
   logic [7:0]      pgm_data_q;
   logic            hs;
   logic            half_end;

   assign in_ready  = (state_q == StPrime) || (state_q == StFill);
   assign hs        = in_valid && in_ready;
   assign half_end  = &wr_addr_q[AW-2:0];
   assign dac_reset = (state_q == StRst);
   assign busy      = (state_q != StIdle);

   assign pgm_we      = pgm_we_q;
   assign pgm_address = pgm_address_q;
   assign pgm_data    = pgm_data_q;
   assign dac_play    = dac_play_q;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = 1'b0;
      wr_addr_d = wr_addr_q;
      if (hs) begin
         wr_addr_d = wr_addr_q + 1'b1;
      end
      if (state_q == StRst) begin
         wr_addr_d = '0;
      end
      if (stop) begin
         state_d = StIdle;
      end else if (start) begin
         state_d = StRst;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StRst: begin
               rst_cnt_d = 1'b1;
               if (rst_cnt_q) begin
                  state_d = StPrime;
               end
            end
            StPrime: begin
               if (hs && half_end) begin
                  state_d = StFill;
               end
            end
            StFill: begin
               // Next half still being read by the DAC: hold off until it moves on.
               if (hs && half_end && (!wr_addr_q[AW-1] == stat_q)) begin
                  state_d = StWait;
               end
            end
            StWait: begin
               if (stat_q != wr_addr_q[AW-1]) begin
                  state_d = StFill;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q       <= StIdle;
         rst_cnt_q     <= 1'b0;
         wr_addr_q     <= '0;
         stat_q        <= 1'b0;
         play_pend_q   <= 1'b0;
         dac_play_q    <= 1'b0;
         pgm_we_q      <= 1'b1;
         pgm_address_q <= '0;
         pgm_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         wr_addr_q   <= wr_addr_d;
         stat_q      <= dac_status;
         pgm_we_q    <= !hs;
         if (hs) begin
            pgm_address_q <= wr_addr_q;
            pgm_data_q    <= in_data;
         end
         // Play starts only once the final priming byte has been written.
         play_pend_q <= (state_q == StPrime) && (state_d == StFill);
         if ((state_d == StIdle) || (state_d == StRst)) begin
            dac_play_q <= 1'b0;
         end else if (play_pend_q) begin
            dac_play_q <= 1'b1;
         end
      end
   end

`ifdef DAC_FEEDER_UNDERRUN_EN
   logic                  stat_prev_q;
   logic [UNDERRUN_W-1:0] ucnt_q;

   always_ff @(posedge clkin) begin
      if (reset) begin
         stat_prev_q <= 1'b0;
         ucnt_q      <= '0;
      end else begin
         stat_prev_q <= stat_q;
         if (state_q == StRst) begin
            ucnt_q <= '0;
         end else if ((state_q == StFill) && (stat_q != stat_prev_q) &&
                      (stat_q == wr_addr_q[AW-1]) && !(&ucnt_q)) begin
            ucnt_q <= ucnt_q + 1'b1;
         end
      end
   end

   assign underrun_count = ucnt_q;
`else
   assign underrun_count = '0;
`endif

endmodule
